// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one pipelined integer square-root unit among N_REQ requesters.
// Results return through a tag pipe and are held per requester until acknowledged.
module sqrt_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned D_WIDTH  = 20,
  parameter int unsigned Q_WIDTH  = D_WIDTH / 2 - 1,
  parameter int unsigned R_WIDTH  = Q_WIDTH + 1,
  parameter int unsigned SQRT_LAT = R_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ack,
  output logic [N_REQ*(Q_WIDTH+1)-1:0] rsp_root,
  output logic [N_REQ*(R_WIDTH+1)-1:0] rsp_rem,
  output logic                         sq_valid,
  output logic [D_WIDTH-1:0]           sq_data,
  input  logic                         sq_ovalid,
  input  logic [Q_WIDTH:0]             sq_root,
  input  logic [R_WIDTH:0]             sq_rem,
  output logic                         busy,
  output logic                         lat_err
);
  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned RootW = Q_WIDTH + 1;
  localparam int unsigned RemW  = R_WIDTH + 1;

  logic [N_REQ-1:0]   outstanding_q, outstanding_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [IdxW-1:0]    last_grant_q;
  logic               sq_valid_q;
  logic [D_WIDTH-1:0] sq_data_q;
  logic [SQRT_LAT:0]  tag_v_q;
  logic [IdxW-1:0]    tag_idx_q [SQRT_LAT+1];
  logic [RootW-1:0]   root_q [N_REQ];
  logic [RemW-1:0]    rem_q [N_REQ];
  logic               lat_err_q;

  logic [N_REQ-1:0]   eligible, grant, ack_mask;
  logic               grant_any;
  logic [IdxW-1:0]    grant_idx;
  logic [D_WIDTH-1:0] grant_data;
  logic               capture;
  logic [IdxW-1:0]    cap_idx;

  assign eligible = req_valid & ~outstanding_q;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = 32'(last_grant_q) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && eligible[cand[IdxW-1:0]]) begin
        grant_any                = 1'b1;
        grant_idx                = cand[IdxW-1:0];
        grant[cand[IdxW-1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IdxW'(i)) grant_data = req_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  assign req_ready = grant;
  assign capture   = tag_v_q[SQRT_LAT] & sq_ovalid;
  assign cap_idx   = tag_idx_q[SQRT_LAT];
  assign ack_mask  = rsp_valid_q & rsp_ack;

  always_comb begin
    outstanding_d = (outstanding_q | grant) & ~ack_mask;
    rsp_valid_d   = rsp_valid_q & ~ack_mask;
    if (capture) rsp_valid_d[cap_idx] = 1'b1;
  end

  // Stage 0 is loaded with sq_valid; the remaining SQRT_LAT stages track the root unit so the
  // last stage lines up with sq_ovalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      last_grant_q  <= IdxW'(N_REQ - 1);
      sq_valid_q    <= 1'b0;
      sq_data_q     <= '0;
      tag_v_q       <= '0;
      lat_err_q     <= 1'b0;
      for (int k = 0; k <= SQRT_LAT; k++) tag_idx_q[k] <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        root_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      sq_valid_q    <= grant_any;
      tag_v_q[0]    <= grant_any;
      tag_idx_q[0]  <= grant_idx;
      for (int k = 1; k <= SQRT_LAT; k++) begin
        tag_v_q[k]   <= tag_v_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
      if (grant_any) begin
        sq_data_q    <= grant_data;
        last_grant_q <= grant_idx;
      end
      if (capture) begin
        root_q[cap_idx] <= sq_root;
        rem_q[cap_idx]  <= sq_rem;
      end
      if (sq_ovalid != tag_v_q[SQRT_LAT]) lat_err_q <= 1'b1;
    end
  end

  always_comb begin
    rsp_root = '0;
    rsp_rem  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_root[i*RootW +: RootW] = root_q[i];
      rsp_rem[i*RemW +: RemW]    = rem_q[i];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign sq_valid  = sq_valid_q;
  assign sq_data   = sq_data_q;
  assign busy      = |outstanding_q;
  assign lat_err   = lat_err_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural root unit plus a per-cycle reference model of grants,
// result steering and hold/release, driven by directed and random stimulus.
module tb_sqrt_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 20;
  localparam int unsigned QW  = DW / 2 - 1;
  localparam int unsigned RW  = QW + 1;
  localparam int unsigned LAT = RW + 1;
  localparam int unsigned RTW = QW + 1;
  localparam int unsigned RMW = RW + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ack = '0;
  logic [N*RTW-1:0]  rsp_root;
  logic [N*RMW-1:0]  rsp_rem;
  logic              sq_valid;
  logic [DW-1:0]     sq_data;
  logic              sq_ovalid;
  logic [QW:0]       sq_root;
  logic [RW:0]       sq_rem;
  logic              busy;
  logic              lat_err;
  logic              inj = 1'b0;

  sqrt_arbiter #(.N_REQ(N), .D_WIDTH(DW), .Q_WIDTH(QW), .R_WIDTH(RW), .SQRT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_root(rsp_root),
    .rsp_rem(rsp_rem), .sq_valid(sq_valid), .sq_data(sq_data), .sq_ovalid(sq_ovalid),
    .sq_root(sq_root), .sq_rem(sq_rem), .busy(busy), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  function automatic int unsigned isqrt(input longint unsigned d);
    int unsigned r;
    longint unsigned t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = longint'(r | (32'd1 << b));
      if (t * t <= d) r = 32'(t);
    end
    return r;
  endfunction

  // Behavioural root unit: output valid LAT edges after it samples sq_valid.
  logic          ru_v [LAT];
  logic [DW-1:0] ru_d [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin ru_v[k] <= 1'b0; ru_d[k] <= '0; end
    end else begin
      ru_v[0] <= sq_valid;
      ru_d[0] <= sq_data;
      for (int k = 1; k < LAT; k++) begin ru_v[k] <= ru_v[k-1]; ru_d[k] <= ru_d[k-1]; end
    end
  end
  assign sq_ovalid = ru_v[LAT-1] | inj;
  assign sq_root   = (QW+1)'(isqrt(longint'(ru_d[LAT-1])));
  assign sq_rem    = (RW+1)'(ru_d[LAT-1] - DW'(sq_root) * DW'(sq_root));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [N-1:0]   m_out, m_hold, hs;
  int             m_due [N];
  logic [DW-1:0]  m_dat [N];
  logic [RTW-1:0] m_root [N];
  logic [RMW-1:0] m_rem [N];
  int             m_last;
  logic           m_sqv, m_err;
  logic [DW-1:0]  m_sqd;
  int             cyc = 0;

  task automatic model_reset();
    m_out = '0; m_hold = '0; hs = '0; m_last = N - 1; m_sqv = 0; m_err = 0; m_sqd = '0;
    for (int i = 0; i < N; i++) begin
      m_due[i] = -1; m_dat[i] = '0; m_root[i] = '0; m_rem[i] = '0;
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (v[c] && !m_out[c]) return N'(1) << c;
    end
    return '0;
  endfunction

  function automatic logic [N*RTW-1:0] pack_root();
    logic [N*RTW-1:0] r;
    for (int i = 0; i < N; i++) r[i*RTW +: RTW] = m_root[i];
    return r;
  endfunction

  function automatic logic [N*RMW-1:0] pack_rem();
    logic [N*RMW-1:0] r;
    for (int i = 0; i < N; i++) r[i*RMW +: RMW] = m_rem[i];
    return r;
  endfunction

  // One cycle: entered and left at a negedge.
  task automatic tick(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] ack,
                      input logic inj_in);
    logic [N-1:0] g;
    logic due_now;
    req_valid = v; req_data = d; rsp_ack = ack; inj = inj_in;
    #1;
    g = model_grant(v);
    check("req_ready", req_ready, g);
    @(posedge clk);
    cyc++;
    due_now = 0;
    for (int i = 0; i < N; i++) if (m_due[i] == cyc) due_now = 1;
    if (inj_in && !due_now) m_err = 1;
    hs = g;
    m_sqv = |g;
    for (int i = 0; i < N; i++) if (g[i]) begin
      m_out[i] = 1; m_due[i] = cyc + LAT + 1; m_dat[i] = d[i*DW +: DW];
      m_sqd = d[i*DW +: DW]; m_last = i;
    end
    for (int i = 0; i < N; i++) if (m_hold[i] && ack[i]) begin m_hold[i] = 0; m_out[i] = 0; end
    for (int i = 0; i < N; i++) if (m_due[i] == cyc) begin
      m_hold[i] = 1;
      m_root[i] = RTW'(isqrt(longint'(m_dat[i])));
      m_rem[i]  = RMW'(m_dat[i] - DW'(m_root[i]) * DW'(m_root[i]));
      m_due[i]  = -1;
    end
    @(negedge clk);
    check("rsp_valid", rsp_valid, m_hold);
    check("rsp_root", rsp_root, pack_root());
    check("rsp_rem", rsp_rem, pack_rem());
    check("busy", busy, |m_out);
    check("sq_valid", sq_valid, m_sqv);
    check("sq_data", sq_data, m_sqd);
    check("lat_err", lat_err, m_err);
  endtask

  task automatic do_reset();
    rst_n = 0; req_valid = '0; rsp_ack = '0; inj = 0;
    #1;
    model_reset();
    check("rst_sq_valid", sq_valid, 0);
    check("rst_sq_data", sq_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_root", rsp_root, 0);
    check("rst_rsp_rem", rsp_rem, 0);
    check("rst_busy", busy, 0);
    check("rst_lat_err", lat_err, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  logic [N*DW-1:0] cur_d;

  task automatic drain();
    repeat (LAT + 4) tick('0, cur_d, '1, 0);
  endtask

  task automatic run_single(input logic [DW-1:0] val, input int er, input int em);
    int h;
    h = -1;
    cur_d[DW-1:0] = val;
    for (int k = 0; k < 40 && !rsp_valid[0]; k++) begin
      tick(N'(1), cur_d, '0, 0);
      if (hs[0] && h < 0) h = cyc;
    end
    check("single_latency", cyc - h, LAT + 1);
    check("single_root", rsp_root[RTW-1:0], er);
    check("single_rem", rsp_rem[RMW-1:0], em);
    tick(N'(1), cur_d, N'(1), 0);
  endtask

  int q_idx[$];
  int prev, gi, nops, others;
  logic [RTW-1:0] held;
  logic [N-1:0] rv, ra;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // All four requesters from reset
    cur_d = '0;
    cur_d[0*DW +: DW] = 16; cur_d[1*DW +: DW] = 25; cur_d[2*DW +: DW] = 36; cur_d[3*DW +: DW] = 49;
    for (int k = 0; k < LAT + 5; k++) begin
      tick('1, cur_d, '0, 0);
      for (int i = 0; i < N; i++) if (hs[i]) q_idx.push_back(i);
    end
    check("all4_count", q_idx.size(), 4);
    for (int i = 0; i < q_idx.size() && i < 4; i++) check("all4_order", q_idx[i], i);
    check("all4_valid", rsp_valid, 4'hF);
    for (int i = 0; i < N; i++) begin
      check("all4_root", rsp_root[i*RTW +: RTW], 4 + i);
      check("all4_rem", rsp_rem[i*RMW +: RMW], 0);
    end
    drain();

    // Single requests and boundaries
    run_single(20'd1000, 31, 39);
    run_single(20'd0, 0, 0);
    run_single(20'd1048575, 1023, 2046);
    run_single(20'd441, 21, 0);
    drain();

    // Fairness between requesters 0 and 2
    cur_d[0*DW +: DW] = DW'($urandom());
    cur_d[2*DW +: DW] = DW'($urandom());
    prev = -1; nops = 0;
    for (int k = 0; k < 600 && nops < 20; k++) begin
      tick(4'b0101, cur_d, rsp_valid & 4'b0101, 0);
      if (hs != 0) begin
        gi = hs[2] ? 2 : 0;
        if (prev >= 0) check("fair_alternate", gi, (prev == 0) ? 2 : 0);
        prev = gi; nops++;
      end
    end
    check("fair_ops", nops, 20);
    drain();

    // Hold requester 1's result for 30 cycles
    for (int i = 0; i < N; i++) cur_d[i*DW +: DW] = DW'($urandom());
    for (int k = 0; k < 100 && !rsp_valid[1]; k++) tick('1, cur_d, rsp_valid & 4'b1101, 0);
    check("hold_arrived", rsp_valid[1], 1);
    held = rsp_root[RTW +: RTW];
    others = 0;
    for (int k = 0; k < 30; k++) begin
      tick('1, cur_d, rsp_valid & 4'b1101, 0);
      check("hold_root", rsp_root[RTW +: RTW], held);
      check("hold_ready", req_ready[1], 0);
      others += int'(|(hs & 4'b1101));
    end
    check("hold_others_served", others > 0, 1);
    tick('1, cur_d, 4'b0010 | (rsp_valid & 4'b1101), 0);
    tick(4'b0010, cur_d, rsp_valid & 4'b1101, 0);
    drain();

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      rv = N'($urandom());
      ra = N'($urandom());
      for (int i = 0; i < N; i++) if (hs[i] || ($urandom() % 4 == 0)) cur_d[i*DW +: DW] = DW'($urandom());
      tick(rv, cur_d, ra, 0);
    end
    drain();

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) tick(4'b0111, cur_d, '0, 0);
    check("mid_busy", busy, 1);
    tick('0, cur_d, '0, 0);
    do_reset();
    for (int k = 0; k < LAT + 6; k++) tick('0, cur_d, '0, 0);
    check("post_reset_rsp", rsp_valid, 0);

    // Spurious sq_ovalid with no tag in flight
    tick('0, cur_d, '0, 1);
    check("lat_err_set", lat_err, 1);
    for (int k = 0; k < 5; k++) tick('0, cur_d, '0, 0);
    check("lat_err_held", lat_err, 1);
    do_reset();
    check("lat_err_cleared", lat_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
